// File: rtl/sample_sink_pdm.sv
// sample_sink_pdm: captures the signed sample on each rising edge of the
// sample-rate strobe, guards it with a watchdog, and converts the held value
// into a registered 1-bit pulse-density stream (first- or second-order).
module sample_sink_pdm #(
    parameter int DATA_BITS = 12,
    parameter int ORDER     = 1,
    parameter int TIMEOUT   = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_clk,
    input  logic signed [DATA_BITS-1:0] in,
    input  logic                        mute,
    output logic signed [DATA_BITS-1:0] held,
    output logic                        sample_strobe,
    output logic                        stale,
    output logic                        pdm_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int IW    = DATA_BITS + 4;  // second-order integrator width
    localparam int EW    = IW + 2;         // headroom for integrator sums
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    // Clamp a widened integrator sum back into the signed IW-bit range.
    function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
        logic signed [EW-1:0] hi;
        logic signed [EW-1:0] lo;
        hi = {3'b000, {(IW-1){1'b1}}};
        lo = {3'b111, {(IW-1){1'b0}}};
        if (v > hi)
            sat = hi[IW-1:0];
        else if (v < lo)
            sat = lo[IW-1:0];
        else
            sat = v[IW-1:0];
    endfunction

    logic                        sc_q;
    logic                        capture;
    logic [CNT_W-1:0]            wd_cnt;
    logic signed [DATA_BITS-1:0] mod_x;

    // A capture is a 0->1 transition of the strobe as seen at this clock edge.
    assign capture = sample_clk & ~sc_q;

    // Muting replaces the modulator input only; the held sample is untouched.
    assign mod_x = mute ? '0 : held;

    // Previous strobe level for edge detection; cleared by reset so a strobe
    // that is already high right after reset still counts as an edge.
    always_ff @(posedge clk) begin
        if (rst)
            sc_q <= 1'b0;
        else
            sc_q <= sample_clk;
    end

    // Sample capture plus watchdog; a capture beats a coinciding timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            held          <= '0;
            sample_strobe <= 1'b0;
            stale         <= 1'b1;
            wd_cnt        <= '0;
        end else if (capture) begin
            held          <= in;
            sample_strobe <= 1'b1;
            stale         <= 1'b0;
            wd_cnt        <= '0;
        end else begin
            sample_strobe <= 1'b0;
            if (wd_cnt >= TIMEOUT_M1) begin
                // count reaches TIMEOUT on this edge, then stays there
                wd_cnt <= TIMEOUT_C;
                held   <= '0;
                stale  <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
        end
    end

    if (ORDER == 2) begin : g_order2
        localparam logic signed [EW-1:0] FB_MAG =
            {{(EW-DATA_BITS){1'b0}}, 1'b1, {(DATA_BITS-1){1'b0}}};

        logic signed [EW-1:0] fb;
        logic signed [EW-1:0] x_ext;
        logic signed [EW-1:0] s1;
        logic signed [EW-1:0] s2;
        logic signed [IW-1:0] i1;
        logic signed [IW-1:0] i2;
        logic signed [IW-1:0] i1_nxt;
        logic signed [IW-1:0] i2_nxt;

        // CIFB loop: both integrators subtract the half-scale feedback of the
        // previous output bit; the second one integrates the updated first one.
        always_comb begin
            fb     = pdm_out ? FB_MAG : -FB_MAG;
            x_ext  = EW'(mod_x);
            s1     = EW'(i1) + x_ext - fb;
            i1_nxt = sat(s1);
            s2     = EW'(i2) + EW'(i1_nxt) - fb;
            i2_nxt = sat(s2);
        end

        // Integrator state and quantizer output.
        always_ff @(posedge clk) begin
            if (rst) begin
                i1      <= '0;
                i2      <= '0;
                pdm_out <= 1'b0;
            end else begin
                i1      <= i1_nxt;
                i2      <= i2_nxt;
                pdm_out <= ~i2_nxt[IW-1];
            end
        end
    end else begin : g_order1
        logic [DATA_BITS-1:0] acc;
        logic [DATA_BITS-1:0] u;
        logic [DATA_BITS:0]   sum;

        // Offset-binary view of the input: flipping the sign bit maps
        // -2^(N-1)..2^(N-1)-1 onto 0..2^N-1.
        assign u   = {~mod_x[DATA_BITS-1], mod_x[DATA_BITS-2:0]};
        assign sum = {1'b0, acc} + {1'b0, u};

        // Phase accumulator; its carry-out is the output bit.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc     <= '0;
                pdm_out <= 1'b0;
            end else begin
                acc     <= sum[DATA_BITS-1:0];
                pdm_out <= sum[DATA_BITS];
            end
        end
    end

endmodule

// File: tb/tb_sample_sink_pdm.sv
// Bench for sample_sink_pdm: a first-order instance (short watchdog) and a
// second-order instance share stimulus; a per-cycle reference model feeds an
// expectation queue, captured values feed a strobe scoreboard, and density
// windows are checked against closed-form targets.
module tb_sample_sink_pdm;

    localparam int N    = 12;
    localparam int TO_A = 64;
    localparam int TO_B = 4096;
    localparam int HALF = 1 << (N - 1);
    localparam int FULL = 1 << N;
    localparam int IMAX = (1 << (N + 3)) - 1;
    localparam int IMIN = -(1 << (N + 3));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_clk = 1'b0;
    logic mute = 1'b0;
    logic signed [N-1:0] in_s = '0;

    logic signed [N-1:0] held_a, held_b;
    logic strobe_a, strobe_b, stale_a, stale_b, pdm_a, pdm_b;

    always #5 clk = ~clk;

    sample_sink_pdm #(.DATA_BITS(N), .ORDER(1), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst(rst), .sample_clk(sample_clk), .in(in_s), .mute(mute),
        .held(held_a), .sample_strobe(strobe_a), .stale(stale_a), .pdm_out(pdm_a)
    );

    sample_sink_pdm #(.DATA_BITS(N), .ORDER(2), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst(rst), .sample_clk(sample_clk), .in(in_s), .mute(mute),
        .held(held_b), .sample_strobe(strobe_b), .stale(stale_b), .pdm_out(pdm_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [31:0] act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int held;
        int strobe;
        int stale;
        int pdm;
    } exp_t;

    exp_t exp_qa[$];
    exp_t exp_qb[$];
    int   cap_qa[$];
    int   cap_qb[$];

    int m_prev_sc[2];
    int m_held[2];
    int m_since[2];
    int m_stale[2];
    int m_strobe[2];
    int m_acc[2];
    int m_i1[2];
    int m_i2[2];
    int m_pdm[2];

    function automatic int clamp(input int v);
        if (v > IMAX) return IMAX;
        if (v < IMIN) return IMIN;
        return v;
    endfunction

    task automatic model_edge(input int d, input int order, input int timeout);
        int x;
        int fb;
        int s;
        int cap;
        if (rst) begin
            m_prev_sc[d] = 0; m_held[d] = 0; m_since[d] = 0; m_stale[d] = 1;
            m_strobe[d] = 0; m_acc[d] = 0; m_i1[d] = 0; m_i2[d] = 0; m_pdm[d] = 0;
            return;
        end
        x = mute ? 0 : m_held[d];
        if (order == 1) begin
            s = m_acc[d] + x + HALF;
            m_pdm[d] = (s >= FULL) ? 1 : 0;
            m_acc[d] = s % FULL;
        end else begin
            fb = m_pdm[d] ? HALF : -HALF;
            m_i1[d] = clamp(m_i1[d] + x - fb);
            m_i2[d] = clamp(m_i2[d] + m_i1[d] - fb);
            m_pdm[d] = (m_i2[d] >= 0) ? 1 : 0;
        end
        cap = (sample_clk && m_prev_sc[d] == 0) ? 1 : 0;
        m_prev_sc[d] = sample_clk ? 1 : 0;
        m_strobe[d] = cap;
        if (cap) begin
            m_held[d] = int'(in_s);
            m_since[d] = 0;
            m_stale[d] = 0;
        end else begin
            m_since[d]++;
            if (m_since[d] >= timeout) begin
                m_held[d] = 0;
                m_stale[d] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        model_edge(0, 1, TO_A);
        e.held = m_held[0]; e.strobe = m_strobe[0]; e.stale = m_stale[0]; e.pdm = m_pdm[0];
        exp_qa.push_back(e);
        model_edge(1, 2, TO_B);
        e.held = m_held[1]; e.strobe = m_strobe[1]; e.stale = m_stale[1]; e.pdm = m_pdm[1];
        exp_qb.push_back(e);
    end

    // ---------------- monitor ----------------
    task automatic cmp_dut(input string tag, input exp_t e, input logic signed [N-1:0] h,
                           input logic sb, input logic st, input logic pd);
        check({tag, "_held"}, h, e.held);
        check({tag, "_strobe"}, sb, e.strobe);
        check({tag, "_stale"}, st, e.stale);
        check({tag, "_pdm"}, pd, e.pdm);
    endtask

    always @(negedge clk) begin
        if (exp_qa.size() > 0) cmp_dut("a", exp_qa.pop_front(), held_a, strobe_a, stale_a, pdm_a);
        if (exp_qb.size() > 0) cmp_dut("b", exp_qb.pop_front(), held_b, strobe_b, stale_b, pdm_b);
        if (strobe_a === 1'b1) begin
            if (cap_qa.size() == 0) check("a_strobe_unexpected", strobe_a, 0);
            else check("a_cap_held", held_a, cap_qa.pop_front());
        end
        if (strobe_b === 1'b1) begin
            if (cap_qb.size() == 0) check("b_strobe_unexpected", strobe_b, 0);
            else check("b_cap_held", held_b, cap_qb.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    int ph = 0;
    bit cnt_en = 0;
    int ones_a = 0;
    int ones_b = 0;
    int strobes_a = 0;

    task automatic tick(input logic sc, input int v);
        @(negedge clk);
        if (cnt_en) begin
            ones_a += int'(pdm_a);
            ones_b += int'(pdm_b);
            strobes_a += int'(strobe_a);
        end
        if (sc && !sample_clk && !rst) begin
            cap_qa.push_back(v);
            cap_qb.push_back(v);
        end
        sample_clk = sc;
        in_s = v[N-1:0];
    endtask

    task automatic run_per(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            tick(ph < 8, v);
            ph = (ph + 1) % 16;
        end
    endtask

    task automatic count_win(input int v, input int n);
        ones_a = 0; ones_b = 0; strobes_a = 0;
        cnt_en = 1;
        run_per(v, n);
        cnt_en = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_a_held"}, held_a, 0);
        check({tag, "_a_strobe"}, strobe_a, 0);
        check({tag, "_a_stale"}, stale_a, 1);
        check({tag, "_a_pdm"}, pdm_a, 0);
        check({tag, "_b_held"}, held_b, 0);
        check({tag, "_b_strobe"}, strobe_b, 0);
        check({tag, "_b_stale"}, stale_b, 1);
        check({tag, "_b_pdm"}, pdm_b, 0);
    endtask

    task automatic do_reset(input logic sc_hold, input int v);
        @(negedge clk);
        rst = 1'b1; sample_clk = sc_hold; in_s = v[N-1:0];
        @(negedge clk);
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        if (sample_clk) begin
            cap_qa.push_back(v);
            cap_qb.push_back(v);
        end
        tick(sc_hold, v);
        if (sc_hold) begin
            check("post_rst_cap_strobe", strobe_a, 1);
            check("post_rst_cap_held", held_a, v);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no end, required finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int prev;
        int hi_n;
        int lo_n;
        int v;

        repeat (3) @(negedge clk);
        check_reset_vals("rst_init");
        rst = 1'b0;

        // zero input: exact 50% on order 1, alternating bits
        run_per(0, 40);
        prev = int'(pdm_a);
        for (int i = 0; i < 4; i++) begin
            tick(sample_clk, 0);
            check("alt_zero", int'(pdm_a) ^ prev, 1);
            prev = int'(pdm_a);
        end
        count_win(0, 4096);
        check("dens_zero_a", ones_a, 2048);
        check_range("dens_zero_b", ones_b, 2048 - 41, 2048 + 41);

        // positive full scale
        run_per(2047, 40);
        count_win(2047, 4096);
        check("dens_max_a", ones_a, 4095);

        // negative full scale
        run_per(-2048, 40);
        count_win(-2048, 1000);
        check("dens_min_a", ones_a, 0);

        // divide-by-16 strobe with stepping input
        ph = 8;
        ones_a = 0; ones_b = 0; strobes_a = 0;
        cnt_en = 1;
        run_per(100, 16); check("step_held_100", held_a, 100);
        run_per(200, 16); check("step_held_200", held_a, 200);
        run_per(300, 16); check("step_held_300", held_a, 300);
        cnt_en = 0;
        check("step_strobes", strobes_a, 3);

        // watchdog on the 64-cycle instance
        tick(0, 0);
        tick(1, 1000);
        tick(0, 0);
        check("to_cap_strobe", strobe_a, 1);
        check("to_cap_held", held_a, 1000);
        repeat (63) tick(0, 0);
        check("to_before_held", held_a, 1000);
        check("to_before_stale", stale_a, 0);
        tick(0, 0);
        check("to_held", held_a, 0);
        check("to_stale", stale_a, 1);
        check("to_b_not_stale", stale_b, 0);
        tick(1, 500);
        tick(0, 0);
        check("to_recap_stale", stale_a, 0);
        check("to_recap_held", held_a, 500);
        repeat (62) tick(0, 0);
        tick(1, -700);
        check("to_edge_pre_stale", stale_a, 0);
        tick(0, 0);
        check("to_edge_strobe", strobe_a, 1);
        check("to_edge_stale", stale_a, 0);
        check("to_edge_held", held_a, -700);

        // mute with a negative full-scale sample held
        ph = 8;
        run_per(-2048, 40);
        mute = 1'b1;
        run_per(-2048, 10);
        count_win(-2048, 1000);
        check("mute_dens_a", ones_a, 500);
        check("mute_held_a", held_a, -2048);
        check_range("mute_dens_b", ones_b, 490, 510);
        mute = 1'b0;

        // half scale: 75% density
        run_per(1024, 300);
        count_win(1024, 8192);
        check("dens_half_a", ones_a, 6144);
        check_range("dens_half_b", ones_b, 6144 - 82, 6144 + 82);

        // long overload on the second-order loop, then recovery to zero
        run_per(2047, 10000);
        run_per(0, 216);
        count_win(0, 1000);
        check_range("recover_b", ones_b, 490, 510);
        check("recover_a", ones_a, 500);

        // reset mid-stream, once with the strobe held high across release
        run_per(777, 20);
        do_reset(1'b0, 0);
        run_per(-300, 40);
        do_reset(1'b1, 321);
        tick(0, 0);

        // randomized strobe timing, data and mute
        for (int k = 0; k < 250; k++) begin
            hi_n = int'($urandom_range(1, 6));
            lo_n = ($urandom_range(0, 15) == 0) ? int'($urandom_range(60, 110))
                                               : int'($urandom_range(1, 10));
            if ($urandom_range(0, 7) == 0) mute = ~mute;
            for (int i = 0; i < hi_n; i++) begin
                v = int'($urandom_range(0, FULL - 1)) - HALF;
                tick(1, v);
            end
            for (int i = 0; i < lo_n; i++) begin
                v = int'($urandom_range(0, FULL - 1)) - HALF;
                tick(0, v);
            end
        end
        mute = 1'b0;
        repeat (4) tick(0, 0);

        check("cap_left_a", cap_qa.size(), 0);
        check("cap_left_b", cap_qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
